y86_bus_mem: RTL and testbench
==============================

# y86_bus_mem

Unified byte-addressable memory that sits directly downstream of the y86 sequential core's bus (`bus_A`, `bus_RE`, `bus_WE`, `bus_out`, `bus_in`). It serves both instruction fetches and data accesses. Reads are combinational so the core can latch `bus_in` in the same cycle it drives `bus_A`. Writes are synchronous. The block also keeps sticky error flags and saturating access counters for bench and debug visibility.

## Interface
- `ADDR_W`, default 12: byte-address width; capacity is 2^ADDR_W bytes.
- `WPROT_TOP`, default 12'h100: first writable byte address. Used only with `Y86_MEM_WPROT_EN`.
- `CNT_W`, default 16: width of the access counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bus_A`  in  32  byte address from the core.
- `bus_RE`  in  1  read strobe.
- `bus_WE`  in  1  write strobe.
- `bus_out`  in  32  write data from the core, little-endian.
- `bus_in`  out  32  read data to the core, little-endian, combinational.
- `err_oob`  out  1  sticky: an access had `bus_A[31:ADDR_W]` nonzero.
- `err_proto`  out  1  sticky: `bus_RE` and `bus_WE` were high in the same cycle.
- `err_wprot`  out  1  sticky: a write hit the protected region. Constant 0 when `Y86_MEM_WPROT_EN` is undefined.
- `rd_cnt`  out  CNT_W  count of accepted reads, saturating.
- `wr_cnt`  out  CNT_W  count of accepted writes, saturating.

## Operation
- Storage is an array of 2^ADDR_W bytes. Contents are not affected by `rst`.
- Base address `a = bus_A[ADDR_W-1:0]`. The four byte addresses are `a`, `a+1`, `a+2`, `a+3`, each taken modulo 2^ADDR_W, so an access near the top address wraps to address 0.
- Unaligned accesses at any byte offset are required; instruction fetch advances IP by 1, 2 or 3.
- Out-of-range check: only the upper bits of the base address are tested.
- Read, when `bus_RE`=1 and the address is in range and `bus_WE`=0: `bus_in = {m[a+3], m[a+2], m[a+1], m[a]}`.
- `bus_in` is 32'h0 in every other case: `bus_RE`=0, out of range, or protocol error.
- Accepted read: `rd_cnt` increments, holding at all-ones.
- Write, when `bus_WE`=1 and the address is in range and `bus_RE`=0, and the write is not protected: at the clock edge, `m[a+i] <= bus_out[8i+7:8i]` for i = 0..3. `wr_cnt` increments, saturating.
- Rejected write: nothing is written and `wr_cnt` does not change.
- Protocol error (`bus_RE` and `bus_WE` both high): no write, `bus_in`=0, neither counter changes, and `err_proto` is set. If the address is also out of range, `err_oob` is set too.
- Sticky flags set at the edge that ends the offending cycle and clear only on `rst`.
- Reset values: `err_oob`=0, `err_proto`=0, `err_wprot`=0, `rd_cnt`=0, `wr_cnt`=0.
- During reset, `bus_in` still follows the read rule and writes are blocked. The counters and flags hold at 0, and an error detected while `rst` is high is not recorded.
- `rst` asserted in the middle of activity discards nothing, because memory contents persist.

## Timing
- Read latency is 0 cycles: `bus_in` is valid in the same cycle as `bus_A`/`bus_RE` and must settle before the next rising edge. This matches the core latching IR/MDRr on that edge.
- Write takes effect at the rising edge of the strobe cycle.
- A read of the same address in the following cycle returns the new data.
- Read and write in the same cycle are illegal; the result is as described above.
- A write to bytes overlapping the current read address is not forwarded within the same cycle, since same-cycle RE+WE is illegal.
- Counters and flags are visible one cycle after the qualifying access.

## Configuration
- `Y86_MEM_WPROT_EN` defined: writes whose base address is below `WPROT_TOP`, or whose wrapped byte range touches any address below `WPROT_TOP`, are dropped. They set `err_wprot` and do not increment `wr_cnt`. This protects the code segment against runaway stores.
- `Y86_MEM_WPROT_EN` undefined: every in-range legal write is performed, `err_wprot` is tied to 0, and `WPROT_TOP` is unused.

## Test plan
- Preload m[0x10..0x13] = 11,22,33,44. Read at 0x10 -> `bus_in`=32'h44332211, `rd_cnt`=1. Read at 0x11 with m[0x14]=55 -> `bus_in`=32'h55443322.
- Write 32'hDEADBEEF at 0x203, then read 0x203 in the next cycle -> 32'hDEADBEEF. Read byte-lane at 0x205 -> 32'hxxxxDEAD, where the two high bytes are prior contents. `wr_cnt`=1.
- Wrap: write 32'hA1B2C3D4 at 0xFFE with ADDR_W=12 -> m[0xFFE]=D4, m[0xFFF]=C3, m[0x000]=B2, m[0x001]=A1. A read at 0xFFE returns the same word.
- Error cases:
  - RE with `bus_A`=0x1000 -> `bus_in`=0, `err_oob`=1 next cycle, `rd_cnt` unchanged.
  - RE+WE together at 0x20 -> no write, `err_proto`=1.
  - `rst` pulse -> both flags 0, counters 0, memory data unchanged.
- With `Y86_MEM_WPROT_EN`, WPROT_TOP=0x100:
  - Write at 0x0FE -> dropped, `err_wprot`=1, `wr_cnt` unchanged.
  - Write at 0x100 -> performed.
  - Without the macro, the write at 0x0FE is performed and `err_wprot` stays 0.
- Saturation with CNT_W=4: 20 reads -> `rd_cnt`=15 and holds.
- Core co-simulation: a program with a store, a load, a `jnez` loop and a halt runs to `$finish` with the expected register results and no error flag set.

Source files
------------

// File: rtl/y86_bus_mem.sv
// y86_bus_mem: unified byte-addressable memory on the y86 core bus.
// Combinational little-endian reads, synchronous writes, wrap-around byte
// addressing, sticky error flags and saturating access counters.
// Optional feature: define Y86_MEM_WPROT_EN to drop writes that touch any
// byte below WPROT_TOP (code-segment protection).
module y86_bus_mem #(
    parameter int          ADDR_W    = 12,
    parameter int unsigned WPROT_TOP = 'h100,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      bus_A,
    input  logic             bus_RE,
    input  logic             bus_WE,
    input  logic [31:0]      bus_out,
    output logic [31:0]      bus_in,
    output logic             err_oob,
    output logic             err_proto,
    output logic             err_wprot,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] byte_addr [4];
    logic              in_range;
    logic              proto_hit;
    logic              oob_hit;
    logic              rd_ok;
    logic              wr_legal;
    logic              wr_prot;
    logic              wr_ok;

    // Byte lane addresses; the ADDR_W-bit add wraps the top of memory to 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_addr[i] = bus_A[ADDR_W-1:0] + ADDR_W'(i);
        end
    end

    assign in_range  = (bus_A >> ADDR_W) == 32'd0;
    assign proto_hit = bus_RE & bus_WE;
    assign oob_hit   = (bus_RE | bus_WE) & ~in_range;
    assign rd_ok     = bus_RE & ~bus_WE & in_range;
    assign wr_legal  = bus_WE & ~bus_RE & in_range;
    assign wr_ok     = wr_legal & ~wr_prot;

`ifdef Y86_MEM_WPROT_EN
    // A write is protected if any of its four wrapped bytes lands below WPROT_TOP.
    always_comb begin
        wr_prot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (32'(byte_addr[i]) < WPROT_TOP) begin
                wr_prot = 1'b1;
            end
        end
    end
`else
    logic unused_wprot_top;
    assign unused_wprot_top = |WPROT_TOP;
    assign wr_prot          = 1'b0;
`endif

    // Zero-latency read path; bus_in is zero for any non-accepted read.
    always_comb begin
        bus_in = '0;
        if (rd_ok) begin
            bus_in = {mem[byte_addr[3]], mem[byte_addr[2]],
                      mem[byte_addr[1]], mem[byte_addr[0]]};
        end
    end

    // Byte-lane store; memory is never cleared and writes are held off during reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[byte_addr[i]] <= bus_out[8*i +: 8];
            end
        end
    end

    // Sticky error flags; anything seen while rst is high is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob   <= 1'b0;
            err_proto <= 1'b0;
            err_wprot <= 1'b0;
        end else begin
            if (oob_hit)            err_oob   <= 1'b1;
            if (proto_hit)          err_proto <= 1'b1;
            if (wr_legal && wr_prot) err_wprot <= 1'b1;
        end
    end

    // Saturating counters of accepted reads and performed writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_ok && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_W'(1);
            if (wr_ok && !(&wr_cnt)) wr_cnt <= wr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_y86_bus_mem.sv
// Scoreboard bench for y86_bus_mem: a byte-array reference model predicts each
// cycle's read data and post-edge counters/flags; a monitor on the falling
// edge pops the predictions and compares. A second instance with 4-bit
// counters shares the stimulus to exercise saturation.
`timescale 1ns/100ps
module tb_y86_bus_mem;

    localparam int          MEM_SIZE  = 4096;
    localparam int unsigned PROT_TOP  = 'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_A = '0;
    logic        bus_RE = 1'b0;
    logic        bus_WE = 1'b0;
    logic [31:0] bus_out = '0;
    logic [31:0] bus_in, bus_in4;
    logic        err_oob, err_proto, err_wprot;
    logic        err_oob4, err_proto4, err_wprot4;
    logic [15:0] rd_cnt, wr_cnt;
    logic [3:0]  rd_cnt4, wr_cnt4;

    always #5 clk = ~clk;

    y86_bus_mem #(.ADDR_W(12), .WPROT_TOP(PROT_TOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
        .bus_out(bus_out), .bus_in(bus_in), .err_oob(err_oob),
        .err_proto(err_proto), .err_wprot(err_wprot),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    y86_bus_mem #(.ADDR_W(12), .WPROT_TOP(PROT_TOP), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
        .bus_out(bus_out), .bus_in(bus_in4), .err_oob(err_oob4),
        .err_proto(err_proto4), .err_wprot(err_wprot4),
        .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
    );

    typedef struct {
        logic [31:0] exp_data;
        logic [31:0] mask;
        int          rd16, wr16, rd4, wr4;
        bit          oob, proto, wprot;
    } rec_t;

    rec_t sb[$];

    byte unsigned mdl_mem [MEM_SIZE];
    bit           mdl_known [MEM_SIZE];
    int           n_reads, n_writes;
    bit           f_oob, f_proto, f_wprot;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int bits);
        int top;
        top = (1 << bits) - 1;
        return (v > top) ? top : v;
    endfunction

    // One bus cycle: drive, predict the response, advance the model, queue it.
    task automatic step(input bit r, input logic [31:0] a, input bit re, input bit we,
                        input logic [31:0] d);
        rec_t rec;
        int   base;
        bit   inr, prot;
        @(posedge clk);
        #1;
        rst = r; bus_A = a; bus_RE = re; bus_WE = we; bus_out = d;
        inr  = (a < MEM_SIZE);
        base = int'(a % MEM_SIZE);
        rec.exp_data = '0;
        rec.mask     = '1;
        if (re && !we && inr) begin
            for (int i = 0; i < 4; i++) begin
                rec.exp_data[8*i +: 8] = mdl_mem[(base + i) % MEM_SIZE];
                if (!mdl_known[(base + i) % MEM_SIZE]) rec.mask[8*i +: 8] = 8'h00;
            end
        end
        prot = 1'b0;
`ifdef Y86_MEM_WPROT_EN
        for (int i = 0; i < 4; i++)
            if ((base + i) % MEM_SIZE < int'(PROT_TOP)) prot = 1'b1;
`endif
        if (r) begin
            n_reads = 0; n_writes = 0;
            f_oob = 0; f_proto = 0; f_wprot = 0;
        end else begin
            if ((re || we) && !inr) f_oob = 1;
            if (re && we) f_proto = 1;
            if (re && !we && inr) n_reads++;
            if (we && !re && inr) begin
                if (prot) f_wprot = 1;
                else begin
                    n_writes++;
                    for (int i = 0; i < 4; i++) begin
                        mdl_mem[(base + i) % MEM_SIZE]   = d[8*i +: 8];
                        mdl_known[(base + i) % MEM_SIZE] = 1'b1;
                    end
                end
            end
        end
        rec.rd16 = sat(n_reads, 16);  rec.wr16 = sat(n_writes, 16);
        rec.rd4  = sat(n_reads, 4);   rec.wr4  = sat(n_writes, 4);
        rec.oob  = f_oob; rec.proto = f_proto; rec.wprot = f_wprot;
        sb.push_back(rec);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, a, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, a, 1'b0, 1'b1, d);
    endtask

    // Monitor: read data is checked in its own cycle, state one cycle later.
    initial begin : monitor
        rec_t r, prev;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                if (have_prev) begin
                    check("rd_cnt",    32'(rd_cnt),    32'(prev.rd16));
                    check("wr_cnt",    32'(wr_cnt),    32'(prev.wr16));
                    check("rd_cnt4",   32'(rd_cnt4),   32'(prev.rd4));
                    check("wr_cnt4",   32'(wr_cnt4),   32'(prev.wr4));
                    check("err_oob",   32'(err_oob),   32'(prev.oob));
                    check("err_proto", 32'(err_proto), 32'(prev.proto));
                    check("err_wprot", 32'(err_wprot), 32'(prev.wprot));
                end
                check("bus_in",  bus_in  & r.mask, r.exp_data & r.mask);
                check("bus_in4", bus_in4 & r.mask, r.exp_data & r.mask);
                prev      = r;
                have_prev = 1'b1;
            end
        end
    end

    initial begin : driver
        int sel, op, wait_cnt;
        logic [31:0] a;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mdl_mem[i] = 8'h00; mdl_known[i] = 1'b0;
        end
        n_reads = 0; n_writes = 0; f_oob = 0; f_proto = 0; f_wprot = 0;

        // Reset with bus activity: writes blocked, errors not recorded.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h1234_5678);
        step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'h0);
        step(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Fill memory so every later read is fully predictable.
        for (int i = 0; i < MEM_SIZE / 4; i++) wr(32'(4 * i), $urandom());

        // Directed cases.
        wr(32'h10, 32'h4433_2211);
        wr(32'h14, 32'h9988_7755);
        rd(32'h10);
        rd(32'h11);
        wr(32'h203, 32'hDEAD_BEEF);
        rd(32'h203);
        rd(32'h205);
        wr(32'hFFE, 32'hA1B2_C3D4);
        rd(32'hFFE);
        rd(32'h000);
        rd(32'hFFF);
        rd(32'h1000);
        step(1'b0, 32'h20, 1'b1, 1'b1, 32'hCAFE_F00D);
        rd(32'h20);
        wr(32'h0FE, 32'h5566_7788);
        rd(32'h0FE);
        wr(32'h100, 32'h0BAD_CAFE);
        rd(32'h100);
        wr(32'h8000_0010, 32'h1111_1111);
        rd(32'h10);
        step(1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
        rd(32'h10);
        rd(32'h203);
        for (int i = 0; i < 20; i++) rd(32'(i));

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 8)       a = ($urandom() & 32'hFFFF_F000) | 32'h0000_1000 | 32'($urandom_range(0, 4095));
            else if (sel < 18) a = 32'(MEM_SIZE - $urandom_range(1, 4));
            else if (sel < 28) a = 32'($urandom_range(250, 260));
            else               a = 32'($urandom_range(0, MEM_SIZE - 1));
            op = $urandom_range(0, 9);
            step($urandom_range(0, 249) == 0, a, (op <= 4) || (op == 8),
                 (op >= 5) && (op <= 8), $urandom());
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
